snake_input_ctrl: RTL and testbench
===================================

// Module: snake_input_ctrl
// PURPOSE
//  Upstream stage of the 7-segment snake game core.
//  - Synchronises and debounces the three active-low push buttons.
//  - Turns button presses into a direction request and rejects 180-degree reversals.
//  - Generates the game step tick. The core advances one segment per tick, using dir.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000    cycles a raw level must stay stable to be accepted (10 ms @ 50 MHz)
//  TICK_DIV         67108864  clk cycles per game step (2^26)
//  INIT_DIR         2'b11     direction after reset (LEFT)
// PORTS
//  clk       in   1  system clock
//  rst       in   1  reset, synchronous, active-low
//  button    in   3  raw push buttons, active-low, asynchronous to clk
//  pause     in   1  1 = freeze the tick counter, no ticks
//  tick      out  1  one-cycle game step pulse
//  dir       out  2  committed direction; changes only in a cycle where tick=1
//  dir_rej   out  1  one-cycle pulse, concurrent with tick: pending request was a reversal
//  btn_db    out  3  debounced button levels, active-low
// BEHAVIOUR
//  Clock and reset
//  - Clock is clk. Reset rst is synchronous, active-low; it clears all state on the same edge.
//  - Reset values: tick=0, dir=INIT_DIR, dir_rej=0, btn_db=3'b111.
//  - Internal reset values: sync flops=1, debounce counters=0, pend_valid=0, tick counter=0.
//  Synchronise and debounce
//  - Each button passes through a 2-flop synchroniser.
//  - Debounce counter: clears when the synced level equals btn_db.
//  - Otherwise it increments. On reaching DEBOUNCE_CYCLES-1, btn_db takes the synced level and the counter clears.
//  - press[i] = one-cycle pulse on a btn_db[i] 1->0 transition.
//  Direction request (any press pulse sets pend_valid and overwrites pend_dir; the last press wins)
//  - press[2] -> DOWN (2'b10). This has top priority.
//  - Otherwise, on press[1] or press[0]:
//    - btn_db[1:0]==2'b00 -> UP (2'b00)
//    - only btn_db[1] low -> LEFT (2'b11)
//    - only btn_db[0] low -> RIGHT (2'b01)
//  Tick
//  - Counter runs 0..TICK_DIV-1 and wraps to 0. While pause=1 it holds its value.
//  - tick is registered and goes high for one cycle after the counter reaches TICK_DIV-1.
//  - Period is exactly TICK_DIV cycles when not paused.
//  Commit (same edge that raises tick)
//  - If pend_valid and pend_dir != (dir ^ 2'b10): dir <= pend_dir.
//  - If pend_valid and it is a reversal: dir unchanged, dir_rej=1 for that cycle.
//  - pend_valid clears on every commit.
//  - A press on the commit edge itself becomes the new pending request for the next tick (set beats clear).
//  - A request equal to the current dir commits as a no-op, with no dir_rej.
//  Other rules
//  - pause=1 never drops a pending request. Debounce keeps running while paused.
//  - Reset mid-debounce or with a request pending discards both. The first tick after reset comes TICK_DIV cycles after release.
//  - Counter width is $clog2(TICK_DIV). All compares are unsigned, with no overflow.
// STRUCTURE
//  - Shared package snake_pkg:
//    - DIR_UP=2'b00, DIR_RIGHT=2'b01, DIR_DOWN=2'b10, DIR_LEFT=2'b11
//    - function opposite(d) = d ^ 2'b10
//    - the game core imports the same constants.
//  - Sub-module snake_debounce (param DEBOUNCE_CYCLES; ports clk, rst, raw, level, fall_pulse).
//    - It contains the synchroniser, the counter and the edge detect. It is instantiated 3 times.
//  - The top holds the request logic, tick counter and commit logic.
// TESTING (bench params DEBOUNCE_CYCLES=4, TICK_DIV=16)
//  1. Release rst, buttons high -> dir=2'b11 and tick=0 during reset; then one-cycle ticks every 16 cycles; dir_rej never set.
//  2. button[0] toggling every 2 cycles for 40 cycles -> btn_db stays 3'b111, no pending request, dir stays 2'b11.
//  3. button[0] held low 10 cycles with dir=LEFT -> next tick has dir=2'b11 and dir_rej=1.
//  4. button[2] low, then button[1] low, between two ticks -> next tick dir=2'b11; with button[2] only -> dir=2'b10.
//  5. pause=1 for 40 cycles after a button[2] press -> no tick, counter frozen; after pause=0 the remaining count is resumed and dir=2'b10 commits.
//  6. Assert rst for one cycle while a request is pending and button[1] is mid-debounce -> dir=2'b11; next tick commits nothing.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: direction encoding, the 180-degree
// reversal helper and the button-to-direction request decode.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_RIGHT = 2'b01;
  localparam dir_t DIR_DOWN  = 2'b10;
  localparam dir_t DIR_LEFT  = 2'b11;

  localparam int unsigned NUM_BUTTONS = 3;

  // Button 2 always means DOWN; buttons 1 and 0 form a two-bit chord.
  localparam int unsigned BTN_DOWN = 2;

  typedef struct packed {
    logic valid;
    dir_t dir;
  } dir_req_t;

  // Flipping bit 1 maps UP<->DOWN and RIGHT<->LEFT.
  function automatic dir_t opposite(input dir_t d);
    return d ^ 2'b10;
  endfunction

  // press is a one-cycle pulse per button, level the debounced (active-low)
  // levels in the same cycle. Any press yields a valid request.
  function automatic dir_req_t decode_request(input logic [NUM_BUTTONS-1:0] press,
                                              input logic [NUM_BUTTONS-1:0] level);
    dir_req_t req;
    req.valid = |press;
    req.dir   = DIR_UP;
    if (press[BTN_DOWN]) begin
      req.dir = DIR_DOWN;
    end else begin
      unique case (level[1:0])
        2'b00:   req.dir = DIR_UP;
        2'b01:   req.dir = DIR_LEFT;   // only button 1 held
        2'b10:   req.dir = DIR_RIGHT;  // only button 0 held
        default: req.dir = DIR_UP;     // no button held; a press cannot produce this
      endcase
    end
    return req;
  endfunction

endpackage

// File: rtl/snake_input_ctrl_if.sv
// Button/pause inputs and tick/direction outputs of the snake input stage.
// master drives the buttons and consumes tick/dir; slave is the input stage.
interface snake_input_ctrl_if;
  import snake_pkg::*;

  logic [NUM_BUTTONS-1:0] button;   // raw, active-low, asynchronous
  logic                   pause;
  logic                   tick;
  dir_t                   dir;
  logic                   dir_rej;
  logic [NUM_BUTTONS-1:0] btn_db;   // debounced, active-low

  modport master (
    output button,
    output pause,
    input  tick,
    input  dir,
    input  dir_rej,
    input  btn_db
  );

  modport slave (
    input  button,
    input  pause,
    output tick,
    output dir,
    output dir_rej,
    output btn_db
  );

endinterface

// File: rtl/snake_debounce.sv
// One push button: 2-flop synchroniser, stability counter and falling-edge
// detect on the debounced level. level is active-low like the raw input.
module snake_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic fall_pulse
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      r_sync;
  logic            w_synced;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;
  logic            r_level;
  logic            w_level_d;
  logic            r_fall;
  logic            w_fall_d;

  assign w_synced = r_sync[1];

  // Bring the asynchronous raw level into the clk domain; idle level is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], raw};
    end
  end

  // Accept a new level only after it has differed from the current one for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    w_cnt_d   = r_cnt;
    w_level_d = r_level;
    if (w_synced == r_level) begin
      w_cnt_d = '0;
    end else if (r_cnt == CntMax) begin
      w_level_d = w_synced;
      w_cnt_d   = '0;
    end else begin
      w_cnt_d = r_cnt + 1'b1;
    end
    w_fall_d = r_level & ~w_level_d;
  end

  // Debounce state and the press pulse, aligned with the first low level cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_d;
      r_level <= w_level_d;
      r_fall  <= w_fall_d;
    end
  end

  assign level      = r_level;
  assign fall_pulse = r_fall;

endmodule

// File: rtl/snake_input_ctrl.sv
// Upstream stage of the snake game core: debounces the three buttons, turns
// presses into a pending direction request, generates the step tick and
// commits the request on each tick unless it would reverse the snake.
module snake_input_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TICK_DIV        = 67108864,
  parameter dir_t        INIT_DIR        = DIR_LEFT
) (
  input  logic               clk,
  input  logic               rst,
  snake_input_ctrl_if.slave  ctrl
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);

  logic [NUM_BUTTONS-1:0] w_button;
  logic [NUM_BUTTONS-1:0] w_btn_db;
  logic [NUM_BUTTONS-1:0] w_press;
  dir_req_t               w_req;

  logic [TickW-1:0] r_tick_cnt;
  logic [TickW-1:0] w_tick_cnt_d;
  logic             w_commit;
  logic             r_tick;

  logic r_pend_valid;
  logic w_pend_valid_d;
  dir_t r_pend_dir;
  dir_t w_pend_dir_d;
  dir_t r_dir;
  dir_t w_dir_d;
  logic r_dir_rej;
  logic w_dir_rej_d;

  assign w_button = ctrl.button;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
    snake_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk        (clk),
      .rst        (rst),
      .raw        (w_button[g]),
      .level      (w_btn_db[g]),
      .fall_pulse (w_press[g])
    );
  end

  assign w_req = decode_request(w_press, w_btn_db);

  // Step counter 0..TICK_DIV-1; pause freezes it so the remaining count resumes.
  always_comb begin
    w_commit     = !ctrl.pause && (r_tick_cnt == TickMax);
    w_tick_cnt_d = r_tick_cnt;
    if (!ctrl.pause) begin
      w_tick_cnt_d = w_commit ? '0 : r_tick_cnt + 1'b1;
    end
  end

  // Commit the pending request on the tick edge; a press on that same edge
  // becomes the next pending request, so the set takes priority over the clear.
  always_comb begin
    w_pend_valid_d = r_pend_valid;
    w_pend_dir_d   = r_pend_dir;
    w_dir_d        = r_dir;
    w_dir_rej_d    = 1'b0;
    if (w_commit && r_pend_valid) begin
      if (r_pend_dir == opposite(r_dir)) begin
        w_dir_rej_d = 1'b1;
      end else begin
        w_dir_d = r_pend_dir;
      end
      w_pend_valid_d = 1'b0;
    end
    if (w_req.valid) begin
      w_pend_valid_d = 1'b1;
      w_pend_dir_d   = w_req.dir;
    end
  end

  // Tick, request and direction state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tick_cnt   <= '0;
      r_tick       <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_dir   <= INIT_DIR;
      r_dir        <= INIT_DIR;
      r_dir_rej    <= 1'b0;
    end else begin
      r_tick_cnt   <= w_tick_cnt_d;
      r_tick       <= w_commit;
      r_pend_valid <= w_pend_valid_d;
      r_pend_dir   <= w_pend_dir_d;
      r_dir        <= w_dir_d;
      r_dir_rej    <= w_dir_rej_d;
    end
  end

  assign ctrl.tick    = r_tick;
  assign ctrl.dir     = r_dir;
  assign ctrl.dir_rej = r_dir_rej;
  assign ctrl.btn_db  = w_btn_db;

  // The game core relies on these: a rejection always rides on a tick, and
  // dir only moves in a tick cycle outside of reset.
  a_rej_with_tick : assert property (@(posedge clk) disable iff (!rst)
    ctrl.dir_rej |-> ctrl.tick);
  a_dir_on_tick : assert property (@(posedge clk) disable iff (!rst)
    ($past(rst) && (ctrl.dir != $past(ctrl.dir))) |-> ctrl.tick);

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Bench for snake_input_ctrl: directed scenarios plus random button/pause/reset
// traffic, every cycle compared against a behavioural model of the stage.
module tb_snake_input_ctrl;

  localparam int unsigned DebCycles = 4;
  localparam int unsigned TickDiv   = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  snake_input_ctrl_if ctrl_if ();

  snake_input_ctrl #(
    .DEBOUNCE_CYCLES (DebCycles),
    .TICK_DIV        (TickDiv),
    .INIT_DIR        (2'b11)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (ctrl_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Raw buttons reach the debouncer two samples late; a level is accepted after
  // it has disagreed with the accepted level for DebCycles samples in a row.
  // A tick occurs on every TickDiv-th unpaused cycle since reset.
  logic [2:0] m_raw1, m_raw2, m_db, m_press;
  int         m_run [3];
  int         m_active;
  logic       m_pend_v;
  logic [1:0] m_pend, m_dir;
  logic       m_tick, m_rej;

  function automatic logic [1:0] ref_request(input logic [2:0] press, input logic [2:0] lvl);
    if (press[2]) return 2'b10;
    if (lvl[1:0] == 2'b00) return 2'b00;
    if (lvl[1] == 1'b0) return 2'b11;
    return 2'b01;
  endfunction

  task automatic model_step();
    if (!rst) begin
      m_raw1 = 3'b111; m_raw2 = 3'b111; m_db = 3'b111; m_press = 3'b000;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
      m_active = 0; m_pend_v = 1'b0; m_pend = 2'b11; m_dir = 2'b11;
      m_tick = 1'b0; m_rej = 1'b0;
      return;
    end
    m_tick = 1'b0;
    m_rej  = 1'b0;
    if (!ctrl_if.pause) begin
      m_active++;
      if (m_active % TickDiv == 0) m_tick = 1'b1;
    end
    if (m_tick && m_pend_v) begin
      if (m_pend == (m_dir ^ 2'b10)) m_rej = 1'b1;
      else m_dir = m_pend;
      m_pend_v = 1'b0;
    end
    if (m_press != 3'b000) begin
      m_pend_v = 1'b1;
      m_pend   = ref_request(m_press, m_db);
    end
    m_press = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (m_raw2[i] == m_db[i]) begin
        m_run[i] = 0;
      end else begin
        m_run[i]++;
        if (m_run[i] == DebCycles) begin
          m_db[i]  = m_raw2[i];
          m_run[i] = 0;
          if (!m_db[i]) m_press[i] = 1'b1;
        end
      end
    end
    m_raw2 = m_raw1;
    m_raw1 = ctrl_if.button;
  endtask

  // One clock: advance the model on the edge, compare outputs 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("tick",    8'(ctrl_if.tick),    8'(m_tick));
    check("dir",     8'(ctrl_if.dir),     8'(m_dir));
    check("dir_rej", 8'(ctrl_if.dir_rej), 8'(m_rej));
    check("btn_db",  8'(ctrl_if.btn_db),  8'(m_db));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_tick(input int bound, output int edges);
    edges = 0;
    do begin
      cycle();
      edges++;
    end while (!ctrl_if.tick && edges < bound);
    check("tick_within_bound", 8'(ctrl_if.tick), 8'd1);
  endtask

  task automatic press_for(input logic [2:0] pattern, input int n);
    ctrl_if.button = pattern;
    run(n);
    ctrl_if.button = 3'b111;
  endtask

  int edges;
  int tick_cnt;
  int hold;
  logic [2:0] rnd_btn;

  initial begin
    ctrl_if.button = 3'b111;
    ctrl_if.pause  = 1'b0;
    rst = 1'b0;
    run(2);
    check("reset_dir",  8'(ctrl_if.dir),  8'h3);
    check("reset_tick", 8'(ctrl_if.tick), 8'h0);

    // 1: ticks every TickDiv cycles from release, no rejections.
    rst = 1'b1;
    wait_tick(40, edges);
    check("first_tick_edges", 8'(edges), 8'(TickDiv));
    wait_tick(40, edges);
    check("tick_period", 8'(edges), 8'(TickDiv));

    // 2: bouncing button 0 never gets accepted.
    for (int c = 0; c < 40; c++) begin
      ctrl_if.button = ((c / 2) % 2 == 1) ? 3'b110 : 3'b111;
      cycle();
    end
    ctrl_if.button = 3'b111;
    check("bounce_btn_db", 8'(ctrl_if.btn_db), 8'h7);
    wait_tick(40, edges);
    check("bounce_dir", 8'(ctrl_if.dir), 8'h3);
    check("bounce_rej", 8'(ctrl_if.dir_rej), 8'h0);

    // 3: RIGHT while moving LEFT is a reversal.
    wait_tick(40, edges);
    press_for(3'b110, 10);
    wait_tick(40, edges);
    check("rev_dir", 8'(ctrl_if.dir), 8'h3);
    check("rev_rej", 8'(ctrl_if.dir_rej), 8'h1);

    // 4a: DOWN then LEFT chord before the tick: last press wins (no-op LEFT).
    wait_tick(40, edges);
    ctrl_if.button = 3'b011;
    run(2);
    ctrl_if.button = 3'b001;
    run(8);
    ctrl_if.button = 3'b111;
    wait_tick(40, edges);
    check("last_wins_dir", 8'(ctrl_if.dir), 8'h3);
    check("last_wins_rej", 8'(ctrl_if.dir_rej), 8'h0);
    // 4b: DOWN alone.
    wait_tick(40, edges);
    press_for(3'b011, 8);
    wait_tick(40, edges);
    check("down_dir", 8'(ctrl_if.dir), 8'h2);
    // RIGHT from DOWN is a legal turn.
    wait_tick(40, edges);
    press_for(3'b110, 8);
    wait_tick(40, edges);
    check("right_dir", 8'(ctrl_if.dir), 8'h1);

    // 5: pause keeps the pending DOWN and the remaining count.
    wait_tick(40, edges);
    press_for(3'b011, 8);
    run(2);
    ctrl_if.pause = 1'b1;
    tick_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (ctrl_if.tick) tick_cnt++;
    end
    check("paused_ticks", 8'(tick_cnt), 8'h0);
    ctrl_if.pause = 1'b0;
    wait_tick(40, edges);
    check("resume_edges", 8'(edges), 8'(TickDiv - 10));
    check("pause_dir", 8'(ctrl_if.dir), 8'h2);

    // 6: reset discards a pending RIGHT and a half-debounced button 1.
    wait_tick(40, edges);
    ctrl_if.button = 3'b110;
    run(9);
    ctrl_if.button = 3'b100;
    run(3);
    ctrl_if.button = 3'b111;
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    wait_tick(40, edges);
    check("post_reset_edges", 8'(edges), 8'(TickDiv));
    check("post_reset_dir",   8'(ctrl_if.dir), 8'h3);
    check("post_reset_rej",   8'(ctrl_if.dir_rej), 8'h0);

    // Random buttons, pause and occasional reset.
    hold = 0;
    rnd_btn = 3'b111;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        rnd_btn = 3'($urandom_range(0, 7));
        hold    = $urandom_range(1, 12);
      end
      hold--;
      ctrl_if.button = rnd_btn;
      if ($urandom_range(0, 19) == 0) ctrl_if.pause = ~ctrl_if.pause;
      rst = ($urandom_range(0, 299) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
